// File: rtl/cpu_bus_master_if.sv
// cpu_bus_master_if: request/response and byte-bus signals of cpu_bus_master
// master modport: the engine (takes i_* requests and bus acks, drives o_* responses and bus strobes)
// slave modport:  the environment side (CPU core plus external bus device)
interface cpu_bus_master_if #(
  parameter int ADDR_W    = 32,
  parameter int BEAT_W    = 8,
  parameter int MAX_BEATS = 4
);
  localparam int DATA_W = BEAT_W * MAX_BEATS;
  localparam int CNT_W  = $clog2(MAX_BEATS + 1);
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic              i_req_dec;
  logic [ADDR_W-1:0] i_req_addr;
  logic [CNT_W-1:0]  i_req_beats;
  logic [DATA_W-1:0] i_req_wdata;
  logic              o_rsp_valid;
  logic [DATA_W-1:0] o_rsp_rdata;
  logic              o_rsp_err;
  logic              o_bus_clk;
  logic              o_bus_we;
  logic [ADDR_W-1:0] o_bus_addr;
  logic [BEAT_W-1:0] o_bus_data;
  logic [BEAT_W-1:0] i_bus_data;
  logic              i_bus_data_ready;
  modport master (
    input  i_req_valid, i_req_we, i_req_dec, i_req_addr, i_req_beats, i_req_wdata,
    input  i_bus_data, i_bus_data_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_bus_clk, o_bus_we, o_bus_addr, o_bus_data
  );
  modport slave (
    output i_req_valid, i_req_we, i_req_dec, i_req_addr, i_req_beats, i_req_wdata,
    output i_bus_data, i_bus_data_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_bus_clk, o_bus_we, o_bus_addr, o_bus_data
  );
endinterface

// File: rtl/cpu_bus_master.sv
// cpu_bus_master: multi-beat request engine driving a four-phase o_bus_clk/i_bus_data_ready byte bus
// Ports: i_clk clock; i_rst synchronous active-high reset; bus (cpu_bus_master_if.master):
//   request  i_req_valid, o_req_ready, i_req_we, i_req_dec, i_req_addr, i_req_beats, i_req_wdata
//   response o_rsp_valid, o_rsp_rdata, o_rsp_err
//   bus      o_bus_clk, o_bus_we, o_bus_addr, o_bus_data, i_bus_data, i_bus_data_ready
module cpu_bus_master #(
  parameter int ADDR_W    = 32,
  parameter int BEAT_W    = 8,
  parameter int MAX_BEATS = 4,
  parameter int TIMEOUT   = 255
) (
  input logic              i_clk,
  input logic              i_rst,
  cpu_bus_master_if.master bus
);
  localparam int DATA_W = BEAT_W * MAX_BEATS;
  localparam int CNT_W  = $clog2(MAX_BEATS + 1);
  localparam int TMO_W  = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, STROBE, RELEASE, DONE} state_t;
  state_t            r_state;
  logic              r_req_ready, r_rsp_valid, r_rsp_err, r_bus_clk, r_bus_we, r_dec;
  logic [CNT_W-1:0]  r_beats, r_k;
  logic [TMO_W-1:0]  r_tmo;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [BEAT_W-1:0] r_bus_data;
  logic [CNT_W-1:0]  w_beats, w_lane0, w_lane, w_lane_nxt;
  logic              w_last, w_tmo_hit;
  // Descending transfers walk the lanes from the top so a push lands little-endian in memory.
  always_comb begin
    w_beats    = bus.i_req_beats == '0 ? CNT_W'(1) :
                 bus.i_req_beats > CNT_W'(MAX_BEATS) ? CNT_W'(MAX_BEATS) : bus.i_req_beats;
    w_lane0    = bus.i_req_dec ? w_beats - CNT_W'(1) : '0;
    w_lane     = r_dec ? r_beats - CNT_W'(1) - r_k : r_k;
    w_lane_nxt = r_dec ? r_beats - CNT_W'(2) - r_k : r_k + CNT_W'(1);
    w_last     = r_k + CNT_W'(1) >= r_beats;
    w_tmo_hit  = TIMEOUT > 0 && r_tmo == TMO_W'(TIMEOUT - 1);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_bus_clk   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_dec       <= 1'b0;
      r_beats     <= '0;
      r_k         <= '0;
      r_tmo       <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_bus_addr  <= '0;
      r_bus_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rsp_valid <= 1'b0;
          if (r_req_ready && bus.i_req_valid) begin
            r_state     <= STROBE;
            r_req_ready <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_bus_clk   <= 1'b1;
            r_bus_we    <= bus.i_req_we;
            r_dec       <= bus.i_req_dec;
            r_beats     <= w_beats;
            r_k         <= '0;
            r_tmo       <= '0;
            r_wdata     <= bus.i_req_wdata;
            r_rdata     <= '0;
            r_bus_addr  <= bus.i_req_addr;
            r_bus_data  <= BEAT_W'(bus.i_req_wdata >> (32'(w_lane0) * BEAT_W));
          end else
            r_req_ready <= 1'b1;
        end
        STROBE: begin
          if (bus.i_bus_data_ready) begin
            if (!r_bus_we)
              r_rdata <= r_rdata | (DATA_W'(bus.i_bus_data) << (32'(w_lane) * BEAT_W));
            r_bus_clk <= 1'b0;
            r_tmo     <= '0;
            r_state   <= RELEASE;
          end else if (w_tmo_hit) begin
            r_bus_clk <= 1'b0;
            r_rsp_err <= 1'b1;
            r_tmo     <= '0;
            r_state   <= DONE;
          end else
            r_tmo <= r_tmo + TMO_W'(1);
        end
        RELEASE: begin
          if (!bus.i_bus_data_ready) begin
            r_tmo <= '0;
            if (w_last)
              r_state <= DONE;
            else begin
              r_k        <= r_k + CNT_W'(1);
              r_bus_addr <= r_dec ? r_bus_addr - ADDR_W'(1) : r_bus_addr + ADDR_W'(1);
              r_bus_data <= BEAT_W'(r_wdata >> (32'(w_lane_nxt) * BEAT_W));
              r_bus_clk  <= 1'b1;
              r_state    <= STROBE;
            end
          end else if (w_tmo_hit) begin
            r_rsp_err <= 1'b1;
            r_tmo     <= '0;
            r_state   <= DONE;
          end else
            r_tmo <= r_tmo + TMO_W'(1);
        end
        DONE: begin
          r_rsp_valid <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.o_req_ready = r_req_ready;
  assign bus.o_rsp_valid = r_rsp_valid;
  assign bus.o_rsp_rdata = r_rdata;
  assign bus.o_rsp_err   = r_rsp_err;
  assign bus.o_bus_clk   = r_bus_clk;
  assign bus.o_bus_we    = r_bus_we;
  assign bus.o_bus_addr  = r_bus_addr;
  assign bus.o_bus_data  = r_bus_data;
endmodule

// File: tb/tb_cpu_bus_master.sv
// tb_cpu_bus_master: randomized and directed transfers checked against a beat-list reference model
module tb_cpu_bus_master;
  localparam int ADDR_W = 32, BEAT_W = 8, MAX_BEATS = 4, TIMEOUT = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cpu_bus_master_if #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .MAX_BEATS(MAX_BEATS)) m ();
  cpu_bus_master #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .MAX_BEATS(MAX_BEATS), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (m)
  );
  int n_assert = 0, n_fail = 0;
  int dly = 0, never_at = -1;
  bit sticky = 1'b0;
  int hi = 0, last_hi = 0, cnt = 0, stab_err = 0;
  bit seen = 1'b0;
  logic [31:0] la[$];
  logic        lw[$];
  logic [7:0]  ld[$];
  logic [7:0]  rd_q[$];
  logic [31:0] exp_a[4];
  logic [7:0]  exp_d[4];
  logic [31:0] exp_rd, last_rdata;
  logic        last_err;
  int          last_cyc;
  // bus device: logs each strobe, acks after dly cycles, returns bytes from rd_q on reads
  always @(negedge clk) begin
    if (!m.o_bus_clk) begin
      if (hi != 0) last_hi = hi;
      hi   = 0;
      seen = 1'b0;
      cnt  = 0;
      if (!sticky) m.i_bus_data_ready = 1'b0;
    end else begin
      hi++;
      if (!seen) begin
        seen = 1'b1;
        la.push_back(m.o_bus_addr);
        lw.push_back(m.o_bus_we);
        ld.push_back(m.o_bus_data);
      end else if (m.o_bus_addr !== la[$] || m.o_bus_we !== lw[$] || m.o_bus_data !== ld[$])
        stab_err++;
      if (m.i_bus_data_ready !== 1'b1 && la.size() - 1 != never_at) begin
        if (cnt >= dly) begin
          m.i_bus_data_ready = 1'b1;
          if (!m.o_bus_we && rd_q.size() > 0) m.i_bus_data = rd_q.pop_front();
          else m.i_bus_data = 8'($urandom);
        end else
          cnt++;
      end
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic we, input logic dec, input logic [31:0] addr,
                       input logic [2:0] beats, input logic [31:0] wdata);
    int t;
    t = 0;
    @(negedge clk);
    while (m.o_req_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_wait", m.o_req_ready, 1);
    la.delete();
    lw.delete();
    ld.delete();
    m.i_req_valid = 1'b1;
    m.i_req_we    = we;
    m.i_req_dec   = dec;
    m.i_req_addr  = addr;
    m.i_req_beats = beats;
    m.i_req_wdata = wdata;
    @(posedge clk);
    #1;
    m.i_req_valid = 1'($urandom);
    m.i_req_we    = 1'($urandom);
    m.i_req_dec   = 1'($urandom);
    m.i_req_addr  = $urandom;
    m.i_req_beats = 3'($urandom);
    m.i_req_wdata = $urandom;
  endtask
  task automatic wait_rsp(output int cyc, output logic got);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (m.o_rsp_valid === 1'b1) begin
        got = 1'b1;
        m.i_req_valid = 1'b0;
      end
    end
  endtask
  // nv >= 0: beat nv is never acked; st: ready stays high after the first ack
  task automatic xfer(input string tag, input logic we, input logic dec, input logic [31:0] addr,
                      input logic [2:0] beats, input logic [31:0] wdata, input int d,
                      input int nv, input bit st, input bit keep_rd);
    int cyc, n, strobes, acked, lane;
    logic got, eerr;
    dly = d;
    never_at = nv;
    sticky = st;
    if (!keep_rd) begin
      rd_q.delete();
      repeat (4) rd_q.push_back(8'($urandom));
    end
    n = beats == 0 ? 1 : (int'(beats) > MAX_BEATS ? MAX_BEATS : int'(beats));
    strobes = nv >= 0 ? nv + 1 : (st ? 1 : n);
    acked = nv >= 0 ? nv : strobes;
    eerr = nv >= 0 || st;
    exp_rd = '0;
    for (int k = 0; k < strobes; k++) begin
      lane = dec ? n - 1 - k : k;
      exp_a[k] = dec ? addr - 32'(k) : addr + 32'(k);
      exp_d[k] = wdata[lane*8 +: 8];
      if (!we && k < acked) exp_rd[lane*8 +: 8] = rd_q[k];
    end
    start(we, dec, addr, beats, wdata);
    wait_rsp(cyc, got);
    last_cyc = cyc;
    last_rdata = m.o_rsp_rdata;
    last_err = m.o_rsp_err;
    chk({tag, "_rsp_seen"}, got, 1);
    chk({tag, "_err"}, m.o_rsp_err, eerr);
    chk({tag, "_rdata"}, m.o_rsp_rdata, exp_rd);
    chk({tag, "_rdy_in_rsp"}, m.o_req_ready, 0);
    chk({tag, "_nbeats"}, la.size(), strobes);
    for (int k = 0; k < strobes && k < la.size(); k++) begin
      chk($sformatf("%s_addr%0d", tag, k), la[k], exp_a[k]);
      chk($sformatf("%s_we%0d", tag, k), lw[k], we);
      if (we) chk($sformatf("%s_data%0d", tag, k), ld[k], exp_d[k]);
    end
    if (!eerr) chk({tag, "_cycles"}, cyc, n * (d + 2) + 2);
    if (nv >= 0) chk({tag, "_strobe_len"}, last_hi, TIMEOUT);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {m.o_rsp_valid, m.o_req_ready}, 2'b01);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t, pulses;
    m.i_req_valid = 1'b0;
    m.i_req_we    = 1'b0;
    m.i_req_dec   = 1'b0;
    m.i_req_addr  = '0;
    m.i_req_beats = '0;
    m.i_req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", m.o_req_ready, 1);
    chk("rst_outputs", {m.o_rsp_valid, m.o_rsp_err, m.o_bus_clk, m.o_bus_we}, 4'b0);
    chk("rst_addr_data", {m.o_bus_addr, m.o_bus_data}, 40'h0);
    chk("rst_rdata", m.o_rsp_rdata, 32'h0);
    rst = 1'b0;
    xfer("lat", 0, 0, 32'h10, 1, 32'h0, 0, -1, 0, 0);
    chk("lat_single_beat", last_cyc, 4);
    xfer("t1", 1, 0, 32'h1234, 1, 32'hA5, 1, -1, 0, 0);
    chk("t1_beat", {la[0], lw[0], ld[0]}, {32'h1234, 1'b1, 8'hA5});
    rd_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    xfer("t2", 0, 0, 32'h2000, 4, 32'h0, 0, -1, 0, 1);
    chk("t2_rdata", last_rdata, 32'h44332211);
    chk("t2_last_addr", la[3], 32'h2003);
    xfer("t3", 1, 1, 32'h01FF, 2, 32'hBEEF, 0, -1, 0, 0);
    chk("t3_beat0", {la[0], ld[0]}, {32'h01FF, 8'hBE});
    chk("t3_beat1", {la[1], ld[1]}, {32'h01FE, 8'hEF});
    xfer("t4", 0, 0, 32'hFFFFFFFF, 2, 32'h0, 2, -1, 0, 0);
    chk("t4_wrap", {la[0], la[1]}, {32'hFFFFFFFF, 32'h0});
    rd_q = '{8'h5C, 8'h77, 8'h88, 8'h99};
    xfer("t5", 0, 0, 32'h4000, 3, 32'h0, 0, 1, 0, 1);
    chk("t5_partial", {last_err, last_rdata}, {1'b1, 32'h5C});
    xfer("sticky", 1, 0, 32'h50, 2, 32'h3C3C, 0, -1, 1, 0);
    xfer("beats0", 1, 1, 32'h60, 0, 32'h12345678, 1, -1, 0, 0);
    xfer("beats7", 0, 1, 32'h1, 7, 32'h0, 0, -1, 0, 0);
    xfer("after_err", 1, 0, 32'h70, 3, 32'h00CAFE01, 1, -1, 0, 0);
    dly = 3;
    never_at = -1;
    sticky = 1'b0;
    rd_q.delete();
    repeat (4) rd_q.push_back(8'($urandom));
    start(0, 0, 32'h3000, 4, 32'h0);
    t = 0;
    while (la.size() < 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid_reached_beat2", {la.size() == 3, m.o_bus_clk}, 2'b11);
    m.i_req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_state", {m.o_bus_clk, m.o_req_ready, m.o_rsp_valid}, 3'b010);
    chk("rst_mid_rdata", m.o_rsp_rdata, 32'h0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (m.o_rsp_valid !== 1'b0) pulses++;
    end
    chk("rst_mid_no_rsp", pulses, 0);
    chk("rst_mid_no_strobe", la.size(), 3);
    xfer("post_rst", 0, 1, 32'h3000, 4, 32'h0, 1, -1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 3);
      a = sel == 0 ? 32'hFFFFFFFF - 32'($urandom_range(0, 2)) :
          sel == 1 ? 32'($urandom_range(0, 2)) : $urandom;
      xfer($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), a, 3'($urandom), $urandom,
           $urandom_range(0, 3), -1, 0, 0);
    end
    chk("bus_stable_in_strobe", stab_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
